sata_oob: RTL



---
 rtl/sata_oob_if.sv | 23 ++
 rtl/sata_oob.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sata_oob_if.sv
// Signal bundle between the OOB sequencer and its PHY / link-layer neighbours.
// master: the sequencer itself; slave: the PHY/link side driving RX status.
interface sata_oob_if;
    logic i_phy_ready;
    logic i_rx_cominit;
    logic i_rx_comwake;
    logic i_rx_valid;
    logic i_rx_align;
    logic o_tx_elecidle;
    logic o_tx_align;
    logic o_link_up;
    logic o_err;

    modport master (
        input  i_phy_ready, i_rx_cominit, i_rx_comwake, i_rx_valid, i_rx_align,
        output o_tx_elecidle, o_tx_align, o_link_up, o_err
    );

    modport slave (
        output i_phy_ready, i_rx_cominit, i_rx_comwake, i_rx_valid, i_rx_align,
        input  o_tx_elecidle, o_tx_align, o_link_up, o_err
    );
endinterface

// File: rtl/sata_oob.sv
// Host-side SATA OOB sequencer: COMRESET/COMWAKE bursts, ALIGN exchange, link up.
// Burst/gap timing is produced by gating TX electrical idle; all outputs are registered.
module sata_oob #(
    parameter int unsigned BURST_CYCLES     = 16,
    parameter int unsigned RESET_GAP_CYCLES = 48,
    parameter int unsigned WAKE_GAP_CYCLES  = 16,
    parameter int unsigned NBURSTS          = 6,
    parameter logic [19:0] TIMEOUT_CYCLES   = 20'd880000,
    parameter int unsigned NSYNC            = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    sata_oob_if.master bus
);
    localparam int unsigned RST_PERIOD  = BURST_CYCLES + RESET_GAP_CYCLES;
    localparam int unsigned WAKE_PERIOD = BURST_CYCLES + WAKE_GAP_CYCLES;
    localparam int unsigned MAX_PERIOD  = (RST_PERIOD > WAKE_PERIOD) ? RST_PERIOD : WAKE_PERIOD;
    localparam int unsigned CW = $clog2(MAX_PERIOD + 1);
    localparam int unsigned BW = $clog2(NBURSTS + 1);
    localparam int unsigned SW = $clog2(NSYNC + 1);

    localparam logic [CW-1:0] BURST_LAST  = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PERIOD - 1);
    localparam logic [CW-1:0] WAKE_LAST   = CW'(WAKE_PERIOD - 1);
    localparam logic [BW-1:0] BURSTS_LAST = BW'(NBURSTS - 1);
    localparam logic [SW-1:0] SYNC_LAST   = SW'(NSYNC - 1);
    localparam logic [19:0]   TIMER_LAST  = TIMEOUT_CYCLES - 20'd1;

    typedef enum logic [3:0] {
        IDLE,
        COMRESET,
        AWAIT_COMINIT,
        AWAIT_NOCOMINIT,
        COMWAKE,
        AWAIT_COMWAKE,
        AWAIT_NOCOMWAKE,
        AWAIT_ALIGN,
        SEND_ALIGN,
        READY
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [BW-1:0] burst_cnt;
    logic [19:0]   timer;
    logic [SW-1:0] sync_cnt;
    logic          timed;
    logic          timeout;
    logic          period_end;

    always_comb begin
        timed      = state inside {AWAIT_COMINIT, AWAIT_NOCOMINIT, AWAIT_COMWAKE,
                                   AWAIT_NOCOMWAKE, AWAIT_ALIGN, SEND_ALIGN};
        timeout    = timed && (timer == TIMER_LAST);
        period_end = (phase_cnt == ((state == COMRESET) ? RST_LAST : WAKE_LAST));
    end

    // Outputs are assigned alongside the state they belong to, so they track the state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state             <= IDLE;
            phase_cnt         <= '0;
            burst_cnt         <= '0;
            timer             <= '0;
            sync_cnt          <= '0;
            bus.o_tx_elecidle <= 1'b1;
            bus.o_tx_align    <= 1'b1;
            bus.o_link_up     <= 1'b0;
            bus.o_err         <= 1'b0;
        end else begin
            bus.o_err <= 1'b0;
            if (!bus.i_phy_ready) begin
                state             <= IDLE;
                phase_cnt         <= '0;
                burst_cnt         <= '0;
                timer             <= '0;
                sync_cnt          <= '0;
                bus.o_tx_elecidle <= 1'b1;
                bus.o_tx_align    <= 1'b1;
                bus.o_link_up     <= 1'b0;
            end else if (timeout) begin
                state             <= COMRESET;
                phase_cnt         <= '0;
                burst_cnt         <= '0;
                timer             <= '0;
                sync_cnt          <= '0;
                bus.o_tx_elecidle <= 1'b0;
                bus.o_tx_align    <= 1'b1;
                bus.o_err         <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state             <= COMRESET;
                        phase_cnt         <= '0;
                        burst_cnt         <= '0;
                        bus.o_tx_elecidle <= 1'b0;
                        bus.o_tx_align    <= 1'b1;
                    end
                    // Shared burst/gap engine; only the gap length differs between the two sequences.
                    COMRESET, COMWAKE: begin
                        if (period_end) begin
                            phase_cnt <= '0;
                            if (burst_cnt == BURSTS_LAST) begin
                                burst_cnt         <= '0;
                                timer             <= '0;
                                state             <= (state == COMRESET) ? AWAIT_COMINIT : AWAIT_COMWAKE;
                                bus.o_tx_elecidle <= 1'b1;
                            end else begin
                                burst_cnt         <= burst_cnt + 1'b1;
                                bus.o_tx_elecidle <= 1'b0;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                            if (phase_cnt == BURST_LAST) bus.o_tx_elecidle <= 1'b1;
                        end
                    end
                    AWAIT_COMINIT: begin
                        if (bus.i_rx_cominit) begin
                            state <= AWAIT_NOCOMINIT;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    AWAIT_NOCOMINIT: begin
                        if (!bus.i_rx_cominit) begin
                            state             <= COMWAKE;
                            phase_cnt         <= '0;
                            burst_cnt         <= '0;
                            bus.o_tx_elecidle <= 1'b0;
                            bus.o_tx_align    <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    AWAIT_COMWAKE: begin
                        if (bus.i_rx_comwake) begin
                            state <= AWAIT_NOCOMWAKE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    AWAIT_NOCOMWAKE: begin
                        if (!bus.i_rx_comwake) begin
                            state             <= AWAIT_ALIGN;
                            timer             <= '0;
                            bus.o_tx_elecidle <= 1'b0;
                            bus.o_tx_align    <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    AWAIT_ALIGN: begin
                        if (bus.i_rx_valid && bus.i_rx_align) begin
                            state          <= SEND_ALIGN;
                            timer          <= '0;
                            sync_cnt       <= '0;
                            bus.o_tx_align <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SEND_ALIGN: begin
                        timer <= timer + 1'b1;
                        if (bus.i_rx_valid) begin
                            if (bus.i_rx_align) begin
                                sync_cnt <= '0;
                            end else if (sync_cnt == SYNC_LAST) begin
                                state          <= READY;
                                bus.o_link_up  <= 1'b1;
                                bus.o_tx_align <= 1'b0;
                            end else begin
                                sync_cnt <= sync_cnt + 1'b1;
                            end
                        end
                    end
                    READY: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
